// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction/data) arbiter onto a single shared memory with registered requests
module mem_arbiter #(
    parameter bit DATA_PRIORITY = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_read,
    input  logic [31:0] instr_mem_address,
    output logic [31:0] instr_mem_rdata,
    output logic        instr_mem_resp,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [3:0]  data_mbe,
    input  logic [31:0] data_mem_address,
    input  logic [31:0] data_mem_wdata,
    output logic [31:0] data_mem_rdata,
    output logic        data_mem_resp,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_mbe,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] INSTR = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    logic [1:0]  r_state;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_mbe;
    logic        r_write;
    logic        w_grant_data;
    logic        w_grant_instr;
    logic        w_in_instr;
    logic        w_in_data;
    logic        w_busy;
    assign w_grant_data  = (data_read | data_write) & (DATA_PRIORITY | ~instr_read);
    assign w_grant_instr = instr_read & ~w_grant_data;
    // a simultaneous read+write is latched as a write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_mbe   <= '0;
            r_write <= 1'b0;
        end else if (r_state == IDLE) begin
            if (w_grant_data) begin
                r_state <= DATA;
                r_addr  <= data_mem_address;
                r_wdata <= data_mem_wdata;
                r_mbe   <= data_mbe;
                r_write <= data_write;
            end else if (w_grant_instr) begin
                r_state <= INSTR;
                r_addr  <= instr_mem_address;
                r_wdata <= '0;
                r_mbe   <= 4'hf;
                r_write <= 1'b0;
            end
        end else if (mem_resp || (r_state != INSTR && r_state != DATA)) begin
            r_state <= IDLE;
        end
    end
    assign w_in_instr      = r_state == INSTR;
    assign w_in_data       = r_state == DATA;
    assign w_busy          = w_in_instr | w_in_data;
    assign mem_read        = w_in_instr | (w_in_data & ~r_write);
    assign mem_write       = w_in_data & r_write;
    assign mem_mbe         = w_busy ? (r_write ? r_mbe : 4'hf) : 4'h0;
    assign mem_address     = w_busy ? r_addr : 32'h0;
    assign mem_wdata       = (w_busy & r_write) ? r_wdata : 32'h0;
    assign instr_mem_resp  = w_in_instr & mem_resp;
    assign instr_mem_rdata = instr_mem_resp ? mem_rdata : 32'h0;
    assign data_mem_resp   = w_in_data & mem_resp;
    assign data_mem_rdata  = (data_mem_resp & ~r_write) ? mem_rdata : 32'h0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter, one instance per DATA_PRIORITY setting
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        instr_read[2];
    logic [31:0] instr_addr[2];
    logic [31:0] instr_rdata[2];
    logic        instr_resp[2];
    logic        data_read[2];
    logic        data_write[2];
    logic [3:0]  data_mbe[2];
    logic [31:0] data_addr[2];
    logic [31:0] data_wdata[2];
    logic [31:0] data_rdata[2];
    logic        data_resp[2];
    logic        mr[2];
    logic        mw[2];
    logic [3:0]  mmbe[2];
    logic [31:0] maddr[2];
    logic [31:0] mwdata[2];
    logic [31:0] mrdata[2];
    logic        mresp[2];
    int          lat[2];
    logic [31:0] key[2];
    logic        force_resp[2];
    int          t_instr[2];
    int          t_data[2];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [33:0] q0[$];
    logic [33:0] q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter #(.DATA_PRIORITY(1'b1)) u_dp (
        .clk(clk), .rst(rst),
        .instr_read(instr_read[0]), .instr_mem_address(instr_addr[0]),
        .instr_mem_rdata(instr_rdata[0]), .instr_mem_resp(instr_resp[0]),
        .data_read(data_read[0]), .data_write(data_write[0]), .data_mbe(data_mbe[0]),
        .data_mem_address(data_addr[0]), .data_mem_wdata(data_wdata[0]),
        .data_mem_rdata(data_rdata[0]), .data_mem_resp(data_resp[0]),
        .mem_read(mr[0]), .mem_write(mw[0]), .mem_mbe(mmbe[0]), .mem_address(maddr[0]),
        .mem_wdata(mwdata[0]), .mem_rdata(mrdata[0]), .mem_resp(mresp[0])
    );
    mem_arbiter #(.DATA_PRIORITY(1'b0)) u_ip (
        .clk(clk), .rst(rst),
        .instr_read(instr_read[1]), .instr_mem_address(instr_addr[1]),
        .instr_mem_rdata(instr_rdata[1]), .instr_mem_resp(instr_resp[1]),
        .data_read(data_read[1]), .data_write(data_write[1]), .data_mbe(data_mbe[1]),
        .data_mem_address(data_addr[1]), .data_mem_wdata(data_wdata[1]),
        .data_mem_rdata(data_rdata[1]), .data_mem_resp(data_resp[1]),
        .mem_read(mr[1]), .mem_write(mw[1]), .mem_mbe(mmbe[1]), .mem_address(maddr[1]),
        .mem_wdata(mwdata[1]), .mem_rdata(mrdata[1]), .mem_resp(mresp[1])
    );

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int k, input logic is_data, input logic c, input logic [31:0] rd);
        if (k == 0) q0.push_back({is_data, c, rd});
        else q1.push_back({is_data, c, rd});
    endtask

    task automatic sb_check(input int k, input logic is_data, input logic [31:0] rd);
        logic [33:0] e;
        if ((k == 0 ? q0.size() : q1.size()) == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp inst %0d port_is_data %0d got %0h expected none", k, is_data, rd);
        end else begin
            if (k == 0) e = q0.pop_front();
            else e = q1.pop_front();
            chk("resp", 160'({is_data, e[32] ? rd : 32'h0}), 160'({e[33], e[32] ? e[31:0] : 32'h0}));
        end
    endtask

    function automatic logic [159:0] outs(input int k);
        return 160'({instr_rdata[k], instr_resp[k], data_rdata[k], data_resp[k],
                     mr[k], mw[k], mmbe[k], maddr[k], mwdata[k]});
    endfunction

    // memory model: responds on the lat-th strobed cycle with address ^ key
    initial begin
        int cnt[2];
        for (int k = 0; k < 2; k++) begin
            cnt[k] = 0;
            mresp[k] = 1'b0;
            mrdata[k] = 32'h0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                cnt[k] = (mr[k] || mw[k]) ? cnt[k] + 1 : 0;
                mresp[k] = force_resp[k] || ((mr[k] || mw[k]) && cnt[k] == lat[k]);
                mrdata[k] = maddr[k] ^ key[k];
                if (mresp[k]) cnt[k] = 0;
            end
        end
    end

    initial begin
        logic prev_resp[2];
        prev_resp[0] = 1'b0;
        prev_resp[1] = 1'b0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                chk("rd_wr_exclusive", 160'(mr[k] && mw[k]), 160'(0));
                if (prev_resp[k]) chk("strobe_in_idle", 160'({mr[k], mw[k]}), 160'(0));
                if (!instr_resp[k]) chk("instr_rdata_idle", 160'(instr_rdata[k]), 160'(0));
                if (!data_resp[k]) chk("data_rdata_idle", 160'(data_rdata[k]), 160'(0));
                if (instr_resp[k]) begin
                    sb_check(k, 1'b0, instr_rdata[k]);
                    t_instr[k] = cyc;
                end
                if (data_resp[k]) begin
                    sb_check(k, 1'b1, data_rdata[k]);
                    t_data[k] = cyc;
                end
                prev_resp[k] = instr_resp[k] || data_resp[k];
            end
        end
    end

    task automatic run_port(input int k, input logic is_data, input logic [31:0] addr, input logic wr,
                            input logic [3:0] mbe, input logic [31:0] wdata, input int exp_n,
                            input logic mutate, input string name);
        int n = 0;
        logic done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (mr[k] || mw[k]) begin
                n++;
                chk(name, 160'({mr[k], mw[k], mmbe[k], maddr[k], wr ? mwdata[k] : 32'h0}),
                    160'({!wr, wr, wr ? mbe : 4'hf, addr, wr ? wdata : 32'h0}));
                if (mutate && n == 1) data_addr[k] = 32'h3000;
            end
            done = is_data ? data_resp[k] : instr_resp[k];
        end
        chk({name, "_done"}, 160'(done), 160'(1));
        chk({name, "_strobes"}, 160'(n), 160'(exp_n));
    endtask

    task automatic collide(input int k, input logic data_first);
        logic ok = 1'b0;
        lat[k] = 1;
        key[k] = 32'h0;
        if (data_first) begin
            push(k, 1'b1, 1'b1, 32'h100);
            push(k, 1'b0, 1'b1, 32'h200);
        end else begin
            push(k, 1'b0, 1'b1, 32'h200);
            push(k, 1'b1, 1'b1, 32'h100);
        end
        instr_addr[k] = 32'h200;
        data_addr[k] = 32'h100;
        instr_read[k] = 1'b1;
        data_read[k] = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (data_resp[k]) data_read[k] = 1'b0;
            if (instr_resp[k]) instr_read[k] = 1'b0;
            ok = !data_read[k] && !instr_read[k];
        end
        #1;
        chk("collide_done", 160'(ok), 160'(1));
        chk("collide_gap", 160'(data_first ? t_instr[k] - t_data[k] : t_data[k] - t_instr[k]), 160'(2));
        instr_read[k] = 1'b0;
        data_read[k] = 1'b0;
    endtask

    initial begin
        int prev_t = 0;
        logic seen = 1'b0;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            instr_read[k] = 1'b0; instr_addr[k] = 32'h0;
            data_read[k] = 1'b0; data_write[k] = 1'b0; data_mbe[k] = 4'h0;
            data_addr[k] = 32'h0; data_wdata[k] = 32'h0;
            lat[k] = 1; key[k] = 32'h0; force_resp[k] = 1'b0;
            t_instr[k] = 0; t_data[k] = 0;
        end
        repeat (3) @(negedge clk);
        chk("reset_outs_dp", outs(0), 160'(0));
        chk("reset_outs_ip", outs(1), 160'(0));
        rst = 1'b1;
        @(negedge clk);
        lat[0] = 3;
        key[0] = 32'h8000_0013;
        push(0, 1'b0, 1'b1, 32'h0000_0013);
        instr_addr[0] = 32'h8000_0000;
        instr_read[0] = 1'b1;
        run_port(0, 1'b0, 32'h8000_0000, 1'b0, 4'hf, 32'h0, 3, 1'b0, "fetch");
        instr_read[0] = 1'b0;
        lat[0] = 2;
        push(0, 1'b1, 1'b0, 32'h0);
        data_addr[0] = 32'h0000_1004; data_mbe[0] = 4'b0011; data_wdata[0] = 32'hDEAD_BEEF;
        data_write[0] = 1'b1;
        run_port(0, 1'b1, 32'h0000_1004, 1'b1, 4'b0011, 32'hDEAD_BEEF, 2, 1'b0, "store");
        data_write[0] = 1'b0;
        lat[0] = 1;
        push(0, 1'b1, 1'b0, 32'h0);
        data_addr[0] = 32'h40; data_mbe[0] = 4'b1000; data_wdata[0] = 32'h1234_5678;
        data_read[0] = 1'b1; data_write[0] = 1'b1;
        run_port(0, 1'b1, 32'h40, 1'b1, 4'b1000, 32'h1234_5678, 1, 1'b0, "rw_as_write");
        data_read[0] = 1'b0; data_write[0] = 1'b0;
        lat[0] = 4;
        key[0] = 32'h1111;
        push(0, 1'b1, 1'b1, 32'h3111);
        data_addr[0] = 32'h2000;
        data_read[0] = 1'b1;
        run_port(0, 1'b1, 32'h2000, 1'b0, 4'hf, 32'h0, 4, 1'b1, "addr_hold");
        data_read[0] = 1'b0;
        collide(0, 1'b1);
        collide(1, 1'b0);
        lat[0] = 1;
        key[0] = 32'h0F00;
        instr_read[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(0, 1'b0, 1'b1, 32'h0F10 + 32'(4 * i));
            instr_addr[0] = 32'h10 + 32'(4 * i);
            run_port(0, 1'b0, 32'h10 + 32'(4 * i), 1'b0, 4'hf, 32'h0, 1, 1'b0, "b2b");
            #1;
            if (i > 0) chk("b2b_gap", 160'(t_instr[0] - prev_t), 160'(2));
            prev_t = t_instr[0];
        end
        instr_read[0] = 1'b0;
        lat[0] = 100;
        data_addr[0] = 32'h50; data_mbe[0] = 4'hf; data_wdata[0] = 32'hCAFE_F00D;
        data_write[0] = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = mw[0];
        end
        chk("rst_mid_strobe_seen", 160'(seen), 160'(1));
        #2 rst = 1'b0;
        #1 chk("rst_async_outs", outs(0), 160'(0));
        data_write[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        force_resp[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_stale_resp", 160'({data_resp[0], instr_resp[0], mr[0], mw[0]}), 160'(0));
        force_resp[0] = 1'b0;
        lat[0] = 1;
        repeat (2) @(negedge clk);
        chk("sb_drain", 160'(q0.size() + q1.size()), 160'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
